// File: rtl/rggen_indirect_register_port_pkg.sv
// Shared types for the storage-backed indirect register port.
package rggen_indirect_register_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    localparam logic [1:0] OKAY        = 2'b00;
    localparam logic [1:0] SLAVE_ERROR = 2'b10;

endpackage

// File: rtl/rggen_register_if.sv
// Register bus connection between the bus decoder and one register instance.
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [DATA_WIDTH-1:0]    strobe;
    logic                     select;
    logic                     ready;
    logic [DATA_WIDTH-1:0]    read_data;
    logic [1:0]               status;

    modport control (
        input  request,
        input  address,
        input  write,
        input  write_data,
        input  strobe,
        output select,
        output ready,
        output read_data,
        output status
    );

    modport master (
        output request,
        output address,
        output write,
        output write_data,
        output strobe,
        input  select,
        input  ready,
        input  read_data,
        input  status
    );
endinterface

// File: rtl/rggen_access_timeout.sv
// Wait-cycle counter bounding one storage access; expired stays low when disabled.
module rggen_access_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, i_clear, i_enable};
        assign o_expired     = 1'b0;
    end else begin : g_timeout
        localparam int unsigned    CW    = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);

        logic [CW-1:0] count_q;
        logic [CW-1:0] count_d;

        // Count waiting cycles, holding at the limit until cleared
        always_comb begin
            count_d = count_q;
            if (i_clear) begin
                count_d = '0;
            end else if (i_enable && (count_q != LIMIT)) begin
                count_d = count_q + 1'b1;
            end
        end

        // Counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign o_expired = (count_q == LIMIT);
    end

endmodule

// File: rtl/rggen_indirect_register_port.sv
// Indirect register whose entries live in external storage behind a
// valid/ready port, with index range check, timeout and auto-increment.
module rggen_indirect_register_port
    import rggen_indirect_register_port_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH  = 16,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
    parameter logic [ADDRESS_WIDTH-1:0] END_ADDRESS   = '0,
    parameter int                     DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0]  VALID_BITS     = '1,
    parameter int                     INDEX_WIDTH    = 8,
    parameter int unsigned            DEPTH          = 256,
    parameter bit                     AUTO_INCREMENT = 1'b0,
    parameter int unsigned            TIMEOUT_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rggen_register_if.control      register_if,
    input  logic [INDEX_WIDTH-1:0] i_index,
    output logic                   o_index_inc,
    output logic [INDEX_WIDTH-1:0] o_next_index,
    output logic                   o_ext_valid,
    output logic                   o_ext_write,
    output logic [INDEX_WIDTH-1:0] o_ext_index,
    output logic [DATA_WIDTH-1:0]  o_ext_write_data,
    output logic [DATA_WIDTH-1:0]  o_ext_strobe,
    input  logic                   i_ext_ready,
    input  logic [DATA_WIDTH-1:0]  i_ext_read_data,
    input  logic                   i_ext_error
);

    localparam logic [INDEX_WIDTH:0] DEPTH_EXT  = (INDEX_WIDTH + 1)'(DEPTH);
    localparam logic [INDEX_WIDTH:0] LAST_INDEX = DEPTH_EXT - 1'b1;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] next_index_q, next_index_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             status_q, status_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic                   inc_q, inc_d;

    logic                   address_match;
    logic [INDEX_WIDTH:0]   index_ext;
    logic [INDEX_WIDTH:0]   next_ext;
    logic                   in_range;
    logic                   expired;

    assign address_match = register_if.request
                        && (register_if.address >= START_ADDRESS)
                        && (register_if.address <= END_ADDRESS);

    assign index_ext = {1'b0, i_index};
    assign in_range  = (index_ext < DEPTH_EXT);
    assign next_ext  = (index_ext == LAST_INDEX) ? '0 : index_ext + 1'b1;

    rggen_access_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (state_q != ACCESS),
        .i_enable  ((state_q == ACCESS) && !i_ext_ready),
        .o_expired (expired)
    );

    // Next-state and registered-output values for the access sequence
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        next_index_d = next_index_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        strobe_d     = strobe_q;
        rdata_d      = rdata_q;
        status_d     = status_q;
        ready_d      = 1'b0;
        valid_d      = 1'b0;
        inc_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (address_match) begin
                    index_d      = i_index;
                    next_index_d = next_ext[INDEX_WIDTH-1:0];
                    write_d      = register_if.write;
                    wdata_d      = register_if.write ? (register_if.write_data & VALID_BITS) : '0;
                    strobe_d     = register_if.write ? (register_if.strobe & VALID_BITS) : '0;
                    if (in_range) begin
                        state_d = ACCESS;
                        valid_d = 1'b1;
                    end else begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        rdata_d  = '0;
                        status_d = SLAVE_ERROR;
                    end
                end
            end
            ACCESS: begin
                valid_d = 1'b1;
                // A completion arriving in the expiry cycle still wins
                if (i_ext_ready) begin
                    state_d  = DONE;
                    valid_d  = 1'b0;
                    ready_d  = 1'b1;
                    rdata_d  = write_q ? '0 : (i_ext_read_data & VALID_BITS);
                    status_d = i_ext_error ? SLAVE_ERROR : OKAY;
                    inc_d    = AUTO_INCREMENT && !i_ext_error;
                end else if (expired) begin
                    state_d  = DONE;
                    valid_d  = 1'b0;
                    ready_d  = 1'b1;
                    rdata_d  = '0;
                    status_d = SLAVE_ERROR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            next_index_q <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            strobe_q     <= '0;
            rdata_q      <= '0;
            status_q     <= OKAY;
            ready_q      <= 1'b0;
            valid_q      <= 1'b0;
            inc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            next_index_q <= next_index_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            strobe_q     <= strobe_d;
            rdata_q      <= rdata_d;
            status_q     <= status_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            inc_q        <= inc_d;
        end
    end

    assign register_if.select    = address_match;
    assign register_if.ready     = ready_q;
    assign register_if.read_data = rdata_q;
    assign register_if.status    = status_q;

    assign o_index_inc      = inc_q;
    assign o_next_index     = next_index_q;
    assign o_ext_valid      = valid_q;
    assign o_ext_write      = write_q;
    assign o_ext_index      = index_q;
    assign o_ext_write_data = wdata_q;
    assign o_ext_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_indirect_register_port.sv
// Directed bench for rggen_indirect_register_port: two instances cover the
// masked / range-checked / timeout case and the auto-increment case.
module tb_rggen_indirect_register_port;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rggen_register_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus_a ();
    rggen_register_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus_b ();

    logic [7:0]  a_index, a_next, a_eidx;
    logic        a_inc, a_valid, a_write, a_ext_ready, a_ext_error;
    logic [31:0] a_wdata, a_strobe, a_ext_rdata;

    logic [7:0]  b_index, b_next, b_eidx;
    logic        b_inc, b_valid, b_write, b_ext_ready, b_ext_error;
    logic [31:0] b_wdata, b_strobe, b_ext_rdata;

    rggen_indirect_register_port #(
        .ADDRESS_WIDTH  (16),
        .START_ADDRESS  (16'h0010),
        .END_ADDRESS    (16'h0013),
        .DATA_WIDTH     (32),
        .VALID_BITS     (32'h0000_FFFF),
        .INDEX_WIDTH    (8),
        .DEPTH          (200),
        .AUTO_INCREMENT (1'b0),
        .TIMEOUT_CYCLES (4)
    ) dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .register_if      (bus_a),
        .i_index          (a_index),
        .o_index_inc      (a_inc),
        .o_next_index     (a_next),
        .o_ext_valid      (a_valid),
        .o_ext_write      (a_write),
        .o_ext_index      (a_eidx),
        .o_ext_write_data (a_wdata),
        .o_ext_strobe     (a_strobe),
        .i_ext_ready      (a_ext_ready),
        .i_ext_read_data  (a_ext_rdata),
        .i_ext_error      (a_ext_error)
    );

    rggen_indirect_register_port #(
        .ADDRESS_WIDTH  (16),
        .START_ADDRESS  (16'h0010),
        .END_ADDRESS    (16'h0013),
        .DATA_WIDTH     (32),
        .VALID_BITS     (32'hFFFF_FFFF),
        .INDEX_WIDTH    (8),
        .DEPTH          (4),
        .AUTO_INCREMENT (1'b1),
        .TIMEOUT_CYCLES (15)
    ) dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .register_if      (bus_b),
        .i_index          (b_index),
        .o_index_inc      (b_inc),
        .o_next_index     (b_next),
        .o_ext_valid      (b_valid),
        .o_ext_write      (b_write),
        .o_ext_index      (b_eidx),
        .o_ext_write_data (b_wdata),
        .o_ext_strobe     (b_strobe),
        .i_ext_ready      (b_ext_ready),
        .i_ext_read_data  (b_ext_rdata),
        .i_ext_error      (b_ext_error)
    );

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req_a(input logic [15:0] addr, input logic wr, input logic [31:0] wd, input logic [31:0] st);
        bus_a.request    = 1'b1;
        bus_a.address    = addr;
        bus_a.write      = wr;
        bus_a.write_data = wd;
        bus_a.strobe     = st;
    endtask

    task automatic req_b(input logic [15:0] addr, input logic wr, input logic [31:0] wd, input logic [31:0] st);
        bus_b.request    = 1'b1;
        bus_b.address    = addr;
        bus_b.write      = wr;
        bus_b.write_data = wd;
        bus_b.strobe     = st;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_idx  [4];
        logic [7:0] exp_next [4];
        logic [7:0] load_val;
        logic       load_en;

        exp_idx  = '{8'd2, 8'd3, 8'd0, 8'd1};
        exp_next = '{8'd3, 8'd0, 8'd1, 8'd2};

        rst_n = 1'b0;
        bus_a.request = 1'b0; bus_a.address = '0; bus_a.write = 1'b0; bus_a.write_data = '0; bus_a.strobe = '0;
        bus_b.request = 1'b0; bus_b.address = '0; bus_b.write = 1'b0; bus_b.write_data = '0; bus_b.strobe = '0;
        a_index = '0; a_ext_ready = 1'b0; a_ext_rdata = '0; a_ext_error = 1'b0;
        b_index = '0; b_ext_ready = 1'b0; b_ext_rdata = '0; b_ext_error = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_valid",  a_valid, 0);
        check("rst_write",  a_write, 0);
        check("rst_eidx",   a_eidx, 0);
        check("rst_wdata",  a_wdata, 0);
        check("rst_strobe", a_strobe, 0);
        check("rst_inc",    a_inc, 0);
        check("rst_next",   a_next, 0);
        check("rst_ready",  bus_a.ready, 0);
        check("rst_rdata",  bus_a.read_data, 0);
        check("rst_status", bus_a.status, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_ready", bus_b.ready, 0);
        rst_n = 1'b1;
        tick();

        // Address outside the window is ignored
        req_a(16'h0014, 1'b0, '0, '0);
        a_index = 8'd3;
        #1 check("miss_select", bus_a.select, 0);
        tick();
        check("miss_valid", a_valid, 0);
        check("miss_ready", bus_a.ready, 0);
        bus_a.request = 1'b0;
        tick();

        // Read index 3, two wait cycles, request dropped mid-access
        req_a(16'h0010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        a_index = 8'd3;
        #1 check("rd_select", bus_a.select, 1);
        tick();
        check("rd_c1_valid", a_valid, 1);
        check("rd_c1_write", a_write, 0);
        check("rd_c1_eidx",  a_eidx, 3);
        check("rd_c1_wdata", a_wdata, 0);
        check("rd_c1_strb",  a_strobe, 0);
        tick();
        check("rd_c2_valid", a_valid, 1);
        bus_a.request = 1'b0;
        tick();
        check("rd_c3_valid", a_valid, 1);
        check("rd_c3_ready", bus_a.ready, 0);
        a_ext_ready = 1'b1;
        a_ext_rdata = 32'hDEAD_BEEF;
        tick();
        check("rd_ready",  bus_a.ready, 1);
        check("rd_rdata",  bus_a.read_data, 32'h0000_BEEF);
        check("rd_status", bus_a.status, 2'b00);
        check("rd_valid_off", a_valid, 0);
        check("rd_no_inc", a_inc, 0);
        a_ext_ready = 1'b0;
        tick();
        check("rd_ready_one", bus_a.ready, 0);

        // Write index 0 on the auto-increment instance, ready with valid
        req_b(16'h0011, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        b_index = 8'd0;
        tick();
        check("wr_valid", b_valid, 1);
        check("wr_write", b_write, 1);
        check("wr_eidx",  b_eidx, 0);
        check("wr_wdata", b_wdata, 32'h1234_5678);
        check("wr_strb",  b_strobe, 32'hFFFF_FFFF);
        b_ext_ready = 1'b1;
        b_ext_rdata = 32'hAAAA_5555;
        tick();
        check("wr_ready",  bus_b.ready, 1);
        check("wr_rdata",  bus_b.read_data, 0);
        check("wr_status", bus_b.status, 2'b00);
        check("wr_inc",    b_inc, 1);
        check("wr_next",   b_next, 1);
        b_ext_ready = 1'b0;
        bus_b.request = 1'b0;
        tick();
        check("wr_inc_one", b_inc, 0);

        // Out-of-range index 200 with DEPTH 200
        req_a(16'h0013, 1'b0, '0, '0);
        a_index = 8'd200;
        tick();
        check("oor_ready",  bus_a.ready, 1);
        check("oor_status", bus_a.status, 2'b10);
        check("oor_valid",  a_valid, 0);
        check("oor_inc",    a_inc, 0);
        bus_a.request = 1'b0;
        tick();
        check("oor_ready_one", bus_a.ready, 0);
        check("oor_valid2",    a_valid, 0);

        // Timeout of 4: valid for 5 cycles, then error
        req_a(16'h0010, 1'b0, '0, '0);
        a_index = 8'd7;
        a_ext_rdata = 32'h1111_2222;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("to_c%0d_valid", c), a_valid, 1);
            check($sformatf("to_c%0d_ready", c), bus_a.ready, 0);
        end
        tick();
        check("to_ready",  bus_a.ready, 1);
        check("to_status", bus_a.status, 2'b10);
        check("to_rdata",  bus_a.read_data, 0);
        check("to_valid",  a_valid, 0);
        bus_a.request = 1'b0;
        tick();

        // Following write at last entry: masked payload, normal completion
        req_a(16'h0011, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        a_index = 8'd199;
        tick();
        check("aw_valid", a_valid, 1);
        check("aw_write", a_write, 1);
        check("aw_eidx",  a_eidx, 199);
        check("aw_wdata", a_wdata, 32'h0000_5678);
        check("aw_strb",  a_strobe, 32'h0000_FFFF);
        a_ext_ready = 1'b1;
        a_ext_rdata = 32'h9999_9999;
        tick();
        check("aw_ready",  bus_a.ready, 1);
        check("aw_status", bus_a.status, 2'b00);
        check("aw_rdata",  bus_a.read_data, 0);
        check("aw_inc",    a_inc, 0);
        check("aw_next",   a_next, 0);
        a_ext_ready = 1'b0;
        bus_a.request = 1'b0;
        tick();

        // Auto-increment burst from index 2 with DEPTH 4, last access errors
        b_index = 8'd2;
        for (int i = 0; i < 4; i++) begin
            req_b(16'h0012, 1'b0, '0, '0);
            tick();
            check($sformatf("ai%0d_eidx", i), b_eidx, exp_idx[i]);
            b_ext_ready = 1'b1;
            b_ext_rdata = 32'hC0DE_0000 + 32'(i);
            b_ext_error = (i == 3);
            tick();
            check($sformatf("ai%0d_ready", i), bus_b.ready, 1);
            check($sformatf("ai%0d_status", i), bus_b.status, (i == 3) ? 2'b10 : 2'b00);
            check($sformatf("ai%0d_rdata", i), bus_b.read_data, 32'hC0DE_0000 + 32'(i));
            check($sformatf("ai%0d_inc", i), b_inc, (i == 3) ? 1'b0 : 1'b1);
            check($sformatf("ai%0d_next", i), b_next, exp_next[i]);
            load_en  = b_inc;
            load_val = b_next;
            b_ext_ready = 1'b0;
            b_ext_error = 1'b0;
            bus_b.request = 1'b0;
            tick();
            if (load_en) b_index = load_val;
        end

        // Asynchronous reset in the second access cycle
        req_b(16'h0010, 1'b0, '0, '0);
        b_index = 8'd1;
        tick();
        check("ar_c1_valid", b_valid, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("ar_valid",  b_valid, 0);
        check("ar_ready",  bus_b.ready, 0);
        check("ar_eidx",   b_eidx, 0);
        check("ar_next",   b_next, 0);
        check("ar_inc",    b_inc, 0);
        check("ar_rdata",  bus_b.read_data, 0);
        check("ar_status", bus_b.status, 2'b00);
        bus_b.request = 1'b0;
        tick();
        check("ar_no_ready", bus_b.ready, 0);
        rst_n = 1'b1;
        tick();
        req_b(16'h0010, 1'b0, '0, '0);
        b_index = 8'd1;
        tick();
        check("pr_valid", b_valid, 1);
        check("pr_eidx",  b_eidx, 1);
        b_ext_ready = 1'b1;
        b_ext_rdata = 32'h0BAD_F00D;
        tick();
        check("pr_ready",  bus_b.ready, 1);
        check("pr_rdata",  bus_b.read_data, 32'h0BAD_F00D);
        check("pr_status", bus_b.status, 2'b00);
        check("pr_inc",    b_inc, 1);
        check("pr_next",   b_next, 2);
        b_ext_ready = 1'b0;
        bus_b.request = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
